// File: rtl/io_uart_pkg.sv
// Shared definitions for the IoManager UART transmit port: FSM states,
// status-word bit positions and default line rate.
package io_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int BUSY_BIT  = 0;
    localparam int FULL_BIT  = 1;
    localparam int OVF_BIT   = 2;
    localparam int COUNT_LSB = 8;

    localparam int DEFAULT_BAUD   = 128000;
    localparam int DEFAULT_CLK_HZ = 23000000;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. A push while full is
// accepted only when a pop frees a slot at the same edge.
module uart_tx_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CW-1:0]     o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter towards the PC: CPU writes are queued
// in a FIFO and shifted out LSB first; a status word exposes busy/full/overflow.
module uart_tx_port
    import io_uart_pkg::*;
#(
    parameter  int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter  int BAUD       = DEFAULT_BAUD,
    parameter  int FIFO_DEPTH = 8,
    localparam int DIV        = CLK_HZ / BAUD,
    localparam int BW         = (DIV > 1) ? $clog2(DIV) : 1,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        iCpuClock,
    input  logic        iCpuReset,
    input  logic        iDoTxWrite,
    input  logic [7:0]  iTxData,
    input  logic        iDoStatusRead,
    output logic [15:0] oTxStatus,
    output logic        oUartTx
);

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    tx_state_t   r_state, w_state_n;
    logic [BW-1:0] r_baud, w_baud_n;
    logic [2:0]  r_bit, w_bit_n;
    logic [7:0]  r_shift, w_shift_n;
    logic        r_tx, w_tx_n;
    logic        r_ovf;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic [CW-1:0] w_count;
    logic        w_baud_last;
    logic        w_drop;

    uart_tx_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (iCpuClock),
        .i_reset (iCpuReset),
        .i_push  (iDoTxWrite),
        .i_data  (iTxData),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_drop      = iDoTxWrite && w_full && !w_pop;

    always_comb begin
        w_state_n = r_state;
        w_baud_n  = r_baud;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_head;
                    w_baud_n  = '0;
                    w_state_n = START;
                end
            end
            START: begin
                w_baud_n = r_baud + BW'(1);
                if (w_baud_last) begin
                    w_baud_n  = '0;
                    w_bit_n   = 3'd0;
                    w_state_n = DATA;
                end
            end
            DATA: begin
                w_baud_n = r_baud + BW'(1);
                if (w_baud_last) begin
                    w_baud_n  = '0;
                    w_shift_n = r_shift >> 1;
                    w_bit_n   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_n = STOP;
                end
            end
            STOP: begin
                w_baud_n = r_baud + BW'(1);
                // Chain straight into the next frame so queued bytes leave gap-free.
                if (w_baud_last) begin
                    w_baud_n = '0;
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_n = w_head;
                        w_state_n = START;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase

        case (w_state_n)
            START:   w_tx_n = 1'b0;
            DATA:    w_tx_n = w_shift_n[0];
            default: w_tx_n = 1'b1;
        endcase
    end

    // Line driven from a flop so the pin never glitches on state changes.
    always_ff @(posedge iCpuClock) begin
        if (iCpuReset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_tx    <= w_tx_n;
            if (w_drop)             r_ovf <= 1'b1;
            else if (iDoStatusRead) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge iCpuClock) begin
        r_shift <= w_shift_n;
    end

    always_comb begin
        oTxStatus                     = '0;
        oTxStatus[BUSY_BIT]           = (r_state != IDLE) || !w_empty;
        oTxStatus[FULL_BIT]           = w_full;
        oTxStatus[OVF_BIT]            = r_ovf;
        oTxStatus[COUNT_LSB +: CW]    = w_count;
    end

    assign oUartTx = r_tx;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port: DIV=16 instance for framing/status,
// DIV=4 instance with a serial monitor for a stream of random bytes.
module tb_uart_tx_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr1, rd1, wr2, rd2;
    logic [7:0]  d1, d2;
    logic [15:0] st1, st2;
    logic        tx1, tx2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_port #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(8)) dut1 (
        .iCpuClock     (clk),
        .iCpuReset     (rst),
        .iDoTxWrite    (wr1),
        .iTxData       (d1),
        .iDoStatusRead (rd1),
        .oTxStatus     (st1),
        .oUartTx       (tx1)
    );

    uart_tx_port #(.CLK_HZ(4), .BAUD(1), .FIFO_DEPTH(8)) dut2 (
        .iCpuClock     (clk),
        .iCpuReset     (rst),
        .iDoTxWrite    (wr2),
        .iTxData       (d2),
        .iDoStatusRead (rd2),
        .oTxStatus     (st2),
        .oUartTx       (tx2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Called just after the edge that enters START; ends on the last STOP cycle.
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic exp;
        for (int i = 0; i < 160; i++) begin
            if (i / 16 == 0)      exp = 1'b0;
            else if (i / 16 == 9) exp = 1'b1;
            else                  exp = b[i / 16 - 1];
            chk(tag, {15'd0, tx1}, {15'd0, exp});
            if (i < 159) tick();
        end
    endtask

    logic [7:0] rbytes [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr1 = 0; rd1 = 0; d1 = 0; wr2 = 0; rd2 = 0; d2 = 0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_line", {15'd0, tx1}, 16'h0001);
        chk("reset_status", st1, 16'h0000);
        repeat (5) tick();
        chk("idle_line", {15'd0, tx1}, 16'h0001);
        chk("idle_status", st1, 16'h0000);

        // Single frame 0x55
        wr1 = 1; d1 = 8'h55;
        tick();
        wr1 = 0;
        chk("w55_queued", st1, 16'h0101);
        chk("w55_line_k", {15'd0, tx1}, 16'h0001);
        tick();
        chk("w55_popped", st1, 16'h0001);
        check_frame("frame55", 8'h55);
        chk("w55_busy_stop", st1, 16'h0001);
        tick();
        chk("w55_done_status", st1, 16'h0000);
        chk("w55_done_line", {15'd0, tx1}, 16'h0001);

        // Back-to-back frames
        wr1 = 1; d1 = 8'hA3;
        tick();
        d1 = 8'h0F;
        tick();
        wr1 = 0;
        chk("b2b_status", st1, 16'h0101);
        check_frame("frameA3", 8'hA3);
        tick();
        chk("b2b_second_status", st1, 16'h0001);
        check_frame("frame0F", 8'h0F);
        tick();
        chk("b2b_done_status", st1, 16'h0000);

        // Fill and overflow
        wr1 = 1;
        for (int i = 0; i < 9; i++) begin
            d1 = 8'(8'h10 + i);
            tick();
        end
        chk("fill_full", st1, 16'h0803);
        d1 = 8'hEE;
        tick();
        wr1 = 0;
        chk("ovf_set", st1, 16'h0807);
        rd1 = 1;
        chk("ovf_read_preclear", st1, 16'h0807);
        tick();
        rd1 = 0;
        chk("ovf_cleared", st1, 16'h0803);
        repeat (150) tick();
        chk("last_stop_line", {15'd0, tx1}, 16'h0001);
        chk("last_stop_status", st1, 16'h0803);
        wr1 = 1; d1 = 8'h77;
        tick();
        wr1 = 0;
        chk("full_pop_write", st1, 16'h0803);
        chk("next_start_line", {15'd0, tx1}, 16'h0000);

        // Reset mid-frame
        repeat (20) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("midreset_line", {15'd0, tx1}, 16'h0001);
        chk("midreset_status", st1, 16'h0000);
        repeat (5) tick();
        chk("postreset_line", {15'd0, tx1}, 16'h0001);
        chk("postreset_status", st1, 16'h0000);

        // Random stream through the DIV=4 instance with a serial monitor
        for (int i = 0; i < 8; i++) rbytes[i] = 8'($urandom_range(0, 255));
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    wr2 = 1; d2 = rbytes[i];
                    tick();
                end
                wr2 = 0;
            end
            begin
                for (int f = 0; f < 8; f++) begin
                    int n;
                    logic [7:0] got;
                    n = 0;
                    while (tx2 && n < 100) begin
                        tick();
                        n++;
                    end
                    if (n >= 100) begin
                        chk("mon_start_timeout", 16'h0001, 16'h0000);
                        break;
                    end
                    tick(); tick();
                    chk("mon_start_bit", {15'd0, tx2}, 16'h0000);
                    got = 8'h00;
                    for (int j = 0; j < 8; j++) begin
                        repeat (4) tick();
                        got[j] = tx2;
                    end
                    repeat (4) tick();
                    chk("mon_stop_bit", {15'd0, tx2}, 16'h0001);
                    chk("mon_byte", {8'd0, got}, {8'd0, rbytes[f]});
                end
            end
        join
        repeat (10) tick();
        chk("mon_idle_status", st2, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped UART transmitter, the PC-bound counterpart of the COE/UART receive path; drives Minisys_Uart_ToPc.
- Sits inside IoManager next to the LED, switch and tube ports. The CPU writes bytes, the block buffers them in a small FIFO and serialises them as 8N1, LSB first.
- A status word lets polling software detect busy, full and overflow.

Parameters:
- CLK_HZ, 23000000, frequency of iCpuClock in Hz.
- BAUD, 128000, line rate in bit/s.
- DIV, CLK_HZ/BAUD (integer division, floor), clocks per bit; must be >= 2.
- FIFO_DEPTH, 8, byte slots; must be a power of two, >= 2.

Ports:
- iCpuClock  in  1  CPU clock; all logic on its rising edge.
- iCpuReset  in  1  synchronous, active-high reset.
- iDoTxWrite  in  1  one-cycle write strobe from the CPU store path.
- iTxData  in  8  byte to enqueue; sampled when iDoTxWrite=1.
- iDoStatusRead  in  1  status read strobe; clears the overflow flag.
- oTxStatus  out  16  [0]=busy (frame in flight or FIFO non-empty), [1]=full, [2]=overflow, [7:3]=0, [15:8]=FIFO count (zero-extended).
- oUartTx  out  1  serial line to the PC; idle high.

Behaviour:
- Reset (synchronous, at the sampling edge): oUartTx=1, FSM in IDLE, FIFO empty, count=0, overflow=0, so oTxStatus=0x0000 from the next cycle. Reset mid-frame aborts the frame: the line goes high at the following edge and queued bytes are discarded.
- Enqueue: at an edge with iDoTxWrite=1 and the FIFO not full, the byte is written and count increments.
- Write while full: the byte is dropped and overflow is set (sticky). Exception: if a pop occurs at the same edge, the write is accepted and count is unchanged.
- Overflow clear: iDoStatusRead=1 clears overflow at that edge. oTxStatus is combinational from registers, so the read returns the pre-clear value. If a write is dropped at the same edge as the read, the set wins.
- FSM states IDLE, START, DATA, STOP.
- IDLE: at an edge where the FIFO is non-empty, pop the head into the shift register, go to START and load the baud counter to 0.
- Latency: a byte written at edge k into an empty FIFO, with the FSM in IDLE, is popped at edge k+1. oUartTx=0 is visible from edge k+1.
- START: oUartTx=0 for DIV cycles, then DATA with bit index 0.
- DATA: oUartTx=shift[0] for DIV cycles per bit. Shift right after each bit. After bit 7, go to STOP.
- STOP: oUartTx=1 for DIV cycles.
- Back-to-back frames: at the end of STOP, if the FIFO is non-empty, pop and enter START at the same edge, so there is no idle gap between frames. Otherwise go to IDLE.
- Frame length: exactly 10*DIV cycles.
- Baud counter: counts 0..DIV-1, resets each bit. Width is $clog2(DIV).
- FIFO: read/write pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1; full when count==FIFO_DEPTH.
- Status timing: busy=1 while state!=IDLE or count!=0. The count field shows only queued bytes, not the byte currently on the line.

Decomposition:
- Shared package io_uart_pkg: the FSM state enum (IDLE/START/DATA/STOP), the status bit-index constants (BUSY_BIT=0, FULL_BIT=1, OVF_BIT=2, COUNT_LSB=8) and the default BAUD.
- One sub-module uart_tx_fifo: synchronous FIFO with push, pop, full, empty and count, and same-edge push+pop when full.
- The FSM, shifter and baud counter stay in uart_tx_port.

Test Plan:
- Reset, then idle with no writes -> oUartTx=1, oTxStatus=0x0000. Assert reset mid-frame -> line high the next cycle, status 0x0000.
- CLK_HZ=16, BAUD=1 (DIV=16); write 0x55 -> line low from edge k+1 for 16 cycles, then bits 1,0,1,0,1,0,1,0 each 16 cycles, then high 16 cycles; busy drops at the end of STOP.
- DIV=16; write 0xA3, 0x0F on consecutive cycles -> two 160-cycle frames with no gap; bit patterns LSB-first 1,1,0,0,0,1,0,1 and 1,1,1,1,0,0,0,0.
- Fill with 9 writes while the first frame is in flight, then one more write -> 10th write dropped, status = 0x0807 (count 8, full, overflow, busy); iDoStatusRead -> overflow=0 the next cycle.
- Write at the final STOP-cycle edge while full -> write accepted, count stays 8, overflow stays 0.
- Randomised bytes at DIV=4 checked by a UART monitor model -> received stream equals the accepted write stream.
